pipelined_add_sub: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor. It is the next generation of the team's ripple-carry adder: the carry chain is split into STAGES registered chunks, with carry-out and signed overflow outputs and a per-transaction add/subtract mode. Operands enter and results leave through valid/ready handshakes, so the block drops into streaming datapaths. Each cycle's critical path is one CHUNK-bit ripple.

---
 rtl/pipelined_add_sub.sv | 128 ++++++++++++
 tb/tb_pipelined_add_sub.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined N-bit adder/subtractor with valid/ready handshakes
//
// Purpose: splits an N-bit ripple add/subtract into STAGES registered chunks of
// CHUNK = N/STAGES bits, so each cycle only ripples through one chunk.
// A result appears STAGES cycles after its operands are accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and mode valid this cycle
//   in_ready   block accepts operands this cycle (low only while the output is stalled)
//   num1       operand A
//   num2       operand B
//   sub        0: A+B, 1: A-B (latched with the operands)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result modulo 2^N
//   cout       carry out of bit N-1 (for subtraction, 1 = no borrow)
//   ovf        signed two's-complement overflow

module pipelined_add_sub #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] num1,
    input  logic [N-1:0] num2,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CHUNK = N / STAGES;

    generate
        if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
            $error("pipelined_add_sub: need N >= 2, 1 <= STAGES <= N and N divisible by STAGES");
        end
    endgenerate

    // Per-stage registers. Stage k holds the operands (A and the already
    // inverted B'), the sum chunks finished so far and the carry out of chunk k.
    logic [STAGES-1:0]        v_r;
    logic [STAGES-1:0]        c_r;
    logic [STAGES-1:0][N-1:0] a_r;
    logic [STAGES-1:0][N-1:0] b_r;
    logic [STAGES-1:0][N-1:0] s_r;

    // What each stage sees at its input: stage 0 from the ports, stage k from stage k-1.
    logic [STAGES-1:0]        v_src;
    logic [STAGES-1:0]        c_src;
    logic [STAGES-1:0][N-1:0] a_src;
    logic [STAGES-1:0][N-1:0] b_src;
    logic [STAGES-1:0][N-1:0] s_src;
    logic [STAGES-1:0][N-1:0] s_nx;
    logic [STAGES-1:0]        c_nx;
    logic [CHUNK:0]           part;

    logic stall;

    // Global stall: the whole pipe freezes while the head result waits, so
    // bubbles are never squeezed out and nothing is dropped or duplicated.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        // Subtraction is A + ~B + 1: the +1 enters as the stage-0 carry-in.
        v_src[0] = in_valid;
        a_src[0] = num1;
        b_src[0] = sub ? ~num2 : num2;
        s_src[0] = '0;
        c_src[0] = sub;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k] = v_r[k-1];
            a_src[k] = a_r[k-1];
            b_src[k] = b_r[k-1];
            s_src[k] = s_r[k-1];
            c_src[k] = c_r[k-1];
        end

        part = '0;
        s_nx = s_src;
        c_nx = '0;
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                 + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_src[k]};
            s_nx[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            c_nx[k]                   = part[CHUNK];
        end
    end

    // Data registers only load behind a valid beat, so the output fields keep
    // their last result while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r <= '0;
            c_r <= '0;
            a_r <= '0;
            b_r <= '0;
            s_r <= '0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= v_src[k];
                if (v_src[k]) begin
                    a_r[k] <= a_src[k];
                    b_r[k] <= b_src[k];
                    s_r[k] <= s_nx[k];
                    c_r[k] <= c_nx[k];
                end
            end
        end
    end

    assign out_valid = v_r[STAGES-1];
    assign sum       = s_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    // Overflow when both addends share a sign that the result does not.
    assign ovf       = (a_r[STAGES-1][N-1] == b_r[STAGES-1][N-1]) &&
                       (s_r[STAGES-1][N-1] != a_r[STAGES-1][N-1]);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - self-checking bench for pipelined_add_sub across four parameter sets

module tb_pipelined_add_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        sub_m;
    logic [31:0] ta;
    logic [31:0] tbv;

    always #5 clk = ~clk;

    logic        o_valid [4];
    logic        o_rdy   [4];
    logic        o_cout  [4];
    logic        o_ovf   [4];
    logic [31:0] o_sum   [4];
    logic [15:0] s16;
    logic [4:0]  s5;
    logic [7:0]  s8;
    logic [31:0] s32;

    assign o_sum[0] = {16'b0, s16};
    assign o_sum[1] = {27'b0, s5};
    assign o_sum[2] = {24'b0, s8};
    assign o_sum[3] = s32;

    pipelined_add_sub #(.N(16), .STAGES(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[0]),
        .num1(ta[15:0]), .num2(tbv[15:0]), .sub(sub_m), .out_valid(o_valid[0]),
        .out_ready(out_ready), .sum(s16), .cout(o_cout[0]), .ovf(o_ovf[0]));

    pipelined_add_sub #(.N(5), .STAGES(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[1]),
        .num1(ta[4:0]), .num2(tbv[4:0]), .sub(sub_m), .out_valid(o_valid[1]),
        .out_ready(out_ready), .sum(s5), .cout(o_cout[1]), .ovf(o_ovf[1]));

    pipelined_add_sub #(.N(8), .STAGES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[2]),
        .num1(ta[7:0]), .num2(tbv[7:0]), .sub(sub_m), .out_valid(o_valid[2]),
        .out_ready(out_ready), .sum(s8), .cout(o_cout[2]), .ovf(o_ovf[2]));

    pipelined_add_sub #(.N(32), .STAGES(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[3]),
        .num1(ta), .num2(tbv), .sub(sub_m), .out_valid(o_valid[3]),
        .out_ready(out_ready), .sum(s32), .cout(o_cout[3]), .ovf(o_ovf[3]));

    typedef struct {
        int     id;
        longint sum;
        bit     c;
        bit     o;
        int     cyc;
    } exp_t;

    exp_t q[$];
    int   nw  [4] = '{16, 5, 8, 32};
    int   lat [4] = '{4, 1, 8, 4};
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   strict   = 1;
    int   sent [4] = '{0, 0, 0, 0};
    int   got  [4] = '{0, 0, 0, 0};
    logic        prev_stall [4];
    logic [31:0] prev_sum   [4];
    logic        prev_c     [4];
    logic        prev_o     [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed readings of the operands.
    function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input int c);
        exp_t   r;
        longint m, h, ua, ub, sa, sb, res;
        m   = (longint'(1) << nw[id]) - 1;
        h   = longint'(1) << (nw[id] - 1);
        ua  = longint'(a) & m;
        ub  = longint'(b) & m;
        sa  = (ua >= h) ? ua - 2 * h : ua;
        sb  = (ub >= h) ? ub - 2 * h : ub;
        res = s ? sa - sb : sa + sb;
        r.id  = id;
        r.sum = (s ? ua - ub : ua + ub) & m;
        r.c   = s ? (ua >= ub) : ((ua + ub) > m);
        r.o   = (res < -h) || (res >= h);
        r.cyc = c;
        return r;
    endfunction

    initial forever @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and handshake monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            for (int d = 0; d < 4; d++) begin
                prev_stall[d] = 1'b0;
                sent[d] = 0;
                got[d]  = 0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("d%0d_in_ready", d), o_rdy[d], !(o_valid[d] && !out_ready));
                if (prev_stall[d]) begin
                    chk($sformatf("d%0d_hold_valid", d), o_valid[d], 1);
                    chk($sformatf("d%0d_hold_sum", d), o_sum[d], prev_sum[d]);
                    chk($sformatf("d%0d_hold_cout", d), o_cout[d], prev_c[d]);
                    chk($sformatf("d%0d_hold_ovf", d), o_ovf[d], prev_o[d]);
                end
                if (o_valid[d] && out_ready) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < q.size(); i++) begin
                        if (q[i].id == d) begin
                            idx = i;
                            break;
                        end
                    end
                    chk($sformatf("d%0d_result_expected", d), idx >= 0, 1);
                    if (idx >= 0) begin
                        chk($sformatf("d%0d_sum", d), o_sum[d], q[idx].sum);
                        chk($sformatf("d%0d_cout", d), o_cout[d], q[idx].c);
                        chk($sformatf("d%0d_ovf", d), o_ovf[d], q[idx].o);
                        if (strict != 0)
                            chk($sformatf("d%0d_latency", d), cyc - q[idx].cyc, lat[d]);
                        q.delete(idx);
                        got[d]++;
                    end
                end
                if (in_valid && o_rdy[d]) begin
                    q.push_back(model(d, ta, tbv, sub_m, cyc));
                    sent[d]++;
                end
                prev_stall[d] = o_valid[d] && !out_ready;
                prev_sum[d]   = o_sum[d];
                prev_c[d]     = o_cout[d];
                prev_o[d]     = o_ovf[d];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_one(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [15:0] es, input logic ec, input logic eo);
        int n;
        ta       = {16'h0, a};
        tbv      = {16'h0, b};
        sub_m    = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!o_valid[0] && n < 20) begin
            step();
            n++;
        end
        chk("dir_latency", n, 4);
        chk("dir_sum", o_sum[0], es);
        chk("dir_cout", o_cout[0], ec);
        chk("dir_ovf", o_ovf[0], eo);
    endtask

    initial begin
        int base;
        int budget;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sub_m     = 1'b0;
        ta        = '0;
        tbv       = '0;

        // Reset state.
        repeat (2) step();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("d%0d_rst_valid", d), o_valid[d], 0);
            chk($sformatf("d%0d_rst_sum", d), o_sum[d], 0);
            chk($sformatf("d%0d_rst_cout", d), o_cout[d], 0);
            chk($sformatf("d%0d_rst_ovf", d), o_ovf[d], 0);
        end
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", o_rdy[0], 1);

        // Reset mid-stream: three adds, then reset while the first result is showing.
        in_valid = 1'b1;
        ta = 32'd1; tbv = 32'd2; step();
        ta = 32'd3; tbv = 32'd4; step();
        ta = 32'd5; tbv = 32'd6; step();
        in_valid = 1'b0;
        step();
        chk("midrst_pre_valid", o_valid[0], 1);
        chk("midrst_pre_sum", o_sum[0], 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid[0], 0);
        chk("midrst_sum", o_sum[0], 0);
        chk("midrst_cout", o_cout[0], 0);
        chk("midrst_ovf", o_ovf[0], 0);
        step();
        rst_n = 1'b1;
        repeat (12) step();
        chk("midrst_no_flushed_output", o_valid[0], 0);
        chk("midrst_no_flushed_count", got[0], 0);

        // Directed carry, overflow and subtraction corners.
        do_one(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_one(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_one(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_one(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        repeat (12) step();

        // Streaming: back-to-back random transactions, out_ready held high.
        strict = 1;
        base   = got[0];
        for (int i = 0; i < 100; i++) begin
            ta       = $urandom;
            tbv      = $urandom;
            sub_m    = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (20) step();
        chk("stream_count", got[0] - base, 100);
        for (int d = 0; d < 4; d++)
            chk($sformatf("d%0d_stream_drained", d), got[d], sent[d]);
        chk("stream_queue_empty", q.size(), 0);

        // Backpressure: out_ready at about 30 percent, random in_valid.
        strict = 0;
        base   = sent[0];
        budget = 0;
        while ((sent[0] - base) < 500 && budget < 6000) begin
            out_ready = ($urandom_range(0, 9) < 3);
            in_valid  = 1'($urandom_range(0, 1));
            ta        = $urandom;
            tbv       = $urandom;
            sub_m     = 1'($urandom_range(0, 1));
            step();
            budget++;
        end
        chk("bp_within_budget", budget < 6000, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) step();
        for (int d = 0; d < 4; d++)
            chk($sformatf("d%0d_bp_no_loss", d), got[d], sent[d]);
        chk("bp_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
